retire_trace_monitor: RTL and testbench
=======================================

// Module: retire_trace_monitor
// PURPOSE
//  Synthesizable, parametrised successor to the bench-side PC/instruction dump for single_cycle.
//  Sits beside the core on o_pc_debug/o_insn_vld and records every retired PC with a cycle stamp
//  into a circular trace buffer. Detects halt conditions (invalid insn, self-loop, timeout) and
//  latches a cause. The buffer can be read back on board (LCD/HEX) or by a bench without hierarchical peeks.
// PARAMETERS
//  PC_W        32     width of traced PC
//  DEPTH       16     trace entries; power of 2, >=2
//  CYC_W       32     cycle counter / stamp width
//  TIMEOUT     20000  cycles without halt before TIMEOUT cause; 0 disables
//  LOOP_LIMIT  8      consecutive retires of identical PC that trigger SELFLOOP; >=2
// PORTS
//  i_clk        in   1              clock, rising edge
//  i_reset      in   1              asynchronous, active-low reset
//  i_pc_debug   in   PC_W           PC of instruction retiring this cycle
//  i_insn_vld   in   1              retire valid this cycle
//  i_clear      in   1              sync pulse: clear buffer/counters, return to IDLE
//  i_rd_idx     in   $clog2(DEPTH)  readback index, 0 = oldest valid entry
//  o_rd_pc      out  PC_W           PC of entry i_rd_idx (1-cycle latency)
//  o_rd_cyc     out  CYC_W          cycle stamp of entry i_rd_idx (1-cycle latency)
//  o_count      out  $clog2(DEPTH)+1  valid entries, saturates at DEPTH
//  o_wrapped    out  1              buffer has overwritten at least one entry
//  o_cycle      out  CYC_W          cycles since leaving reset/clear, saturating
//  o_halt       out  1              sticky halt flag
//  o_halt_cause out  2              00 NONE, 01 INVALID, 10 SELFLOOP, 11 TIMEOUT
// BEHAVIOUR
//  - Reset (i_reset=0, async): state IDLE, wptr=0, count=0, wrapped=0, cycle=0, loop_cnt=0,
//    last_pc=0, all outputs 0. Buffer contents undefined; never exposed (count=0).
//  - i_clear=1: same effect as reset at next edge; overrides all other events that cycle.
//  - FSM IDLE -> RUN on first cycle with i_insn_vld=1 (that retire is captured).
//    RUN -> HALT on INVALID/SELFLOOP/TIMEOUT. HALT is sticky until reset/clear.
//  - o_cycle increments every cycle in IDLE and RUN; frozen in HALT; saturates at 2^CYC_W-1.
//  - Capture (RUN, or the IDLE->RUN cycle) with i_insn_vld=1: write {pc, o_cycle} at wptr;
//    wptr+=1 mod DEPTH; count+=1 saturating at DEPTH; wrapped<=1 when a write lands with count==DEPTH.
//  - Self-loop: if captured pc==last_pc, loop_cnt+=1, else loop_cnt<=1. When loop_cnt reaches
//    LOOP_LIMIT, SELFLOOP. The LOOP_LIMIT-th retire is still captured.
//  - INVALID: in RUN, i_insn_vld=0. Nothing is captured that cycle.
//  - TIMEOUT: o_cycle == TIMEOUT-1 in IDLE or RUN and no other cause that cycle.
//  - Priority on the same cycle: INVALID > SELFLOOP > TIMEOUT.
//    o_halt and o_halt_cause update together, registered, one cycle after the triggering edge input.
//  - No captures in HALT; buffer, count and wptr hold.
//  - Readback: phys = (wrapped ? wptr : 0) + i_rd_idx, mod DEPTH. o_rd_* are registered.
//    Index >= o_count returns stale or undefined data; the consumer must gate on o_count.
//    Reads are allowed in any state, including during capture.
//  - Write and read of the same phys in one cycle returns old data (read-before-write).
// STRUCTURE
//  - Package trace_pkg: typedef enum logic[1:0] {ST_IDLE, ST_RUN, ST_HALT} trace_state_e;
//    typedef enum logic[1:0] {HC_NONE, HC_INVALID, HC_SELFLOOP, HC_TIMEOUT} halt_cause_e.
//  - Sub-module trace_ram: DEPTH x (PC_W+CYC_W), 1 write port, 1 registered read port.
//    No reset on the array.
//  - Top holds the FSM, pointers, counters and comparator.
// TESTING
//  1 Reset/first retire: hold i_reset=0 for 10 cycles -> all outputs 0.
//    Release, insn_vld=1 with pc=0,4,8 -> count=3, rd_idx 0..2 gives pc 0/4/8 with cyc 0/1/2.
//  2 Wrap: DEPTH=16, 20 retires with pc=4*k -> count=16, wrapped=1, rd_idx0=0x10, rd_idx15=0x4C.
//  3 Invalid: 5 retires, then insn_vld=0 -> next cycle halt=1, cause=01, count=5.
//    Later retires are ignored.
//  4 Self-loop: pc=0x100 repeated (j .) -> halt with cause=10 after the 8th retire; count=8.
//    Also: 0x100 x7, 0x104, 0x100 -> no halt.
//  5 Timeout/priority: TIMEOUT=50 with insn_vld=1 and incrementing PC -> cause=11, o_cycle frozen at 50.
//    Force insn_vld=0 on cycle 49 -> cause=01.
//  6 Async reset mid-RUN (between edges) -> outputs 0 immediately.
//    i_clear during HALT -> IDLE, count=0, cause=00.

Source files
------------

// File: rtl/retire_trace_monitor_pkg.sv
// Shared types for the retire trace monitor: FSM states and latched halt causes.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } trace_state_e;

  typedef enum logic [1:0] {
    HC_NONE     = 2'd0,
    HC_INVALID  = 2'd1,
    HC_SELFLOOP = 2'd2,
    HC_TIMEOUT  = 2'd3
  } halt_cause_e;

endpackage

// File: rtl/retire_trace_monitor_ram.sv
// Trace storage: one write port, one registered read port with read-before-write behaviour.
module trace_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the read register is cleared; the array itself is never exposed before it is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rd_data <= '0;
    else if (clr) rd_data <= '0;
    else          rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/retire_trace_monitor.sv
// Records every retired PC with a cycle stamp into a circular buffer and latches the halt cause.
module retire_trace_monitor
  import trace_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int DEPTH      = 16,
  parameter int CYC_W      = 32,
  parameter int TIMEOUT    = 20000,
  parameter int LOOP_LIMIT = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [PC_W-1:0]          i_pc_debug,
  input  logic                     i_insn_vld,
  input  logic                     i_clear,
  input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
  output logic [PC_W-1:0]          o_rd_pc,
  output logic [CYC_W-1:0]         o_rd_cyc,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_wrapped,
  output logic [CYC_W-1:0]         o_cycle,
  output logic                     o_halt,
  output logic [1:0]               o_halt_cause
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(LOOP_LIMIT + 1);
  localparam int unsigned TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CYC_W-1:0] TO_CYC = CYC_W'(TO_M1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [LW-1:0] LOOP_HIT = LW'(LOOP_LIMIT);

  function automatic logic [CYC_W-1:0] sat_inc_cyc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + CYC_W'(1);
  endfunction

  function automatic halt_cause_e pick_cause(input logic inv, input logic lp, input logic to);
    if (inv)     return HC_INVALID;
    else if (lp) return HC_SELFLOOP;
    else if (to) return HC_TIMEOUT;
    return HC_NONE;
  endfunction

  trace_state_e      state;
  halt_cause_e       cause;
  logic [AW-1:0]     wptr;
  logic [CW-1:0]     count;
  logic              wrapped;
  logic [CYC_W-1:0]  cycle;
  logic [LW-1:0]     loop_cnt;
  logic [PC_W-1:0]   last_pc;
  logic              halt;

  logic              active;
  logic              capture;
  logic [LW-1:0]     loop_nxt;
  logic              hit_invalid;
  logic              hit_loop;
  logic              hit_timeout;
  logic              hit_any;
  logic [AW-1:0]     rd_phys;
  logic [PC_W+CYC_W-1:0] rd_data_p1;

  always_comb begin
    active      = (state != ST_HALT);
    capture     = active && i_insn_vld;
    loop_nxt    = (i_pc_debug == last_pc) ? loop_cnt + LW'(1) : LW'(1);
    hit_invalid = (state == ST_RUN) && !i_insn_vld;
    hit_loop    = capture && (loop_nxt == LOOP_HIT);
    hit_timeout = (TIMEOUT != 0) && active && (cycle == TO_CYC);
    hit_any     = hit_invalid || hit_loop || hit_timeout;
    // Once the buffer has wrapped, the oldest entry sits at the write pointer.
    rd_phys     = (wrapped ? wptr : AW'(0)) + i_rd_idx;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= ST_IDLE;
      cause    <= HC_NONE;
      halt     <= 1'b0;
      wptr     <= '0;
      count    <= '0;
      wrapped  <= 1'b0;
      cycle    <= '0;
      loop_cnt <= '0;
      last_pc  <= '0;
    end else if (i_clear) begin
      state    <= ST_IDLE;
      cause    <= HC_NONE;
      halt     <= 1'b0;
      wptr     <= '0;
      count    <= '0;
      wrapped  <= 1'b0;
      cycle    <= '0;
      loop_cnt <= '0;
      last_pc  <= '0;
    end else begin
      if (active) cycle <= sat_inc_cyc(cycle);
      if (capture) begin
        wptr     <= wptr + AW'(1);
        count    <= (count == FULL) ? count : count + CW'(1);
        last_pc  <= i_pc_debug;
        loop_cnt <= loop_nxt;
        if (count == FULL) wrapped <= 1'b1;
      end
      case (state)
        ST_IDLE, ST_RUN: begin
          if (hit_any) begin
            state <= ST_HALT;
            halt  <= 1'b1;
            cause <= pick_cause(hit_invalid, hit_loop, hit_timeout);
          end else if (i_insn_vld) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  trace_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (PC_W + CYC_W)
  ) u_ram (
    .clk     (i_clk),
    .rst_n   (i_reset),
    .clr     (i_clear),
    .wr_en   (capture && !i_clear),
    .wr_addr (wptr),
    .wr_data ({i_pc_debug, cycle}),
    .rd_addr (rd_phys),
    .rd_data (rd_data_p1)
  );

  assign o_rd_pc      = rd_data_p1[PC_W+CYC_W-1:CYC_W];
  assign o_rd_cyc     = rd_data_p1[CYC_W-1:0];
  assign o_count      = count;
  assign o_wrapped    = wrapped;
  assign o_cycle      = cycle;
  assign o_halt       = halt;
  assign o_halt_cause = cause;

endmodule

// File: tb/tb_retire_trace_monitor.sv
// Directed scoreboard bench for retire_trace_monitor (DEPTH=16, TIMEOUT=50, LOOP_LIMIT=8).
module tb_retire_trace_monitor;

  localparam int PC_W = 32;
  localparam int DEPTH = 16;
  localparam int CYC_W = 32;

  logic             clk;
  logic             i_reset;
  logic [PC_W-1:0]  i_pc_debug;
  logic             i_insn_vld;
  logic             i_clear;
  logic [3:0]       i_rd_idx;
  logic [PC_W-1:0]  o_rd_pc;
  logic [CYC_W-1:0] o_rd_cyc;
  logic [4:0]       o_count;
  logic             o_wrapped;
  logic [CYC_W-1:0] o_cycle;
  logic             o_halt;
  logic [1:0]       o_halt_cause;

  retire_trace_monitor #(
    .PC_W(PC_W), .DEPTH(DEPTH), .CYC_W(CYC_W), .TIMEOUT(50), .LOOP_LIMIT(8)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_pc_debug(i_pc_debug), .i_insn_vld(i_insn_vld),
    .i_clear(i_clear), .i_rd_idx(i_rd_idx), .o_rd_pc(o_rd_pc), .o_rd_cyc(o_rd_cyc),
    .o_count(o_count), .o_wrapped(o_wrapped), .o_cycle(o_cycle), .o_halt(o_halt),
    .o_halt_cause(o_halt_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    cnt;
    bit    wr;
    bit    hl;
    int    cs;
    int    cyc;
    bit    rdz;
  } st_t;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic [31:0] cyc;
  } rd_t;

  st_t  st_q[$];
  rd_t  rd_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Read requests travel one cycle alongside the DUT's registered read port.
  always @(posedge clk) rd_vld <= rd_req;

  always begin
    st_t s;
    rd_t r;
    @(negedge clk or negedge i_reset);
    #1;
    while (st_q.size() > 0) begin
      s = st_q.pop_front();
      check({s.nm, ".count"},  64'(o_count),      64'(s.cnt));
      check({s.nm, ".wrapped"}, 64'(o_wrapped),   64'(s.wr));
      check({s.nm, ".halt"},   64'(o_halt),       64'(s.hl));
      check({s.nm, ".cause"},  64'(o_halt_cause), 64'(s.cs));
      check({s.nm, ".cycle"},  64'(o_cycle),      64'(s.cyc));
      if (s.rdz) begin
        check({s.nm, ".rd_pc"},  64'(o_rd_pc),  64'd0);
        check({s.nm, ".rd_cyc"}, 64'(o_rd_cyc), 64'd0);
      end
    end
    if (rd_vld) begin
      if (rd_q.size() == 0) begin
        check("rd_underflow", 64'd1, 64'd0);
      end else begin
        r = rd_q.pop_front();
        check({r.nm, ".pc"},  64'(o_rd_pc),  64'(r.pc));
        check({r.nm, ".cyc"}, 64'(o_rd_cyc), 64'(r.cyc));
      end
    end
  end

  task automatic chk_st(input string nm, input int cnt, input bit wr, input bit hl,
                        input int cs, input int cyc, input bit rdz);
    st_t s;
    s.nm = nm; s.cnt = cnt; s.wr = wr; s.hl = hl; s.cs = cs; s.cyc = cyc; s.rdz = rdz;
    st_q.push_back(s);
  endtask

  task automatic drive(input logic vld, input logic [31:0] pc);
    i_insn_vld = vld;
    i_pc_debug = pc;
    @(negedge clk);
  endtask

  task automatic rd(input string nm, input logic [3:0] idx, input logic [31:0] pc,
                    input logic [31:0] cyc);
    rd_t r;
    r.nm = nm; r.pc = pc; r.cyc = cyc;
    rd_q.push_back(r);
    i_rd_idx = idx;
    rd_req = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    i_insn_vld = 1'b0;
    @(negedge clk);
    i_clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b0;
    i_pc_debug = '0;
    i_insn_vld = 1'b0;
    i_clear = 1'b0;
    i_rd_idx = '0;

    // 1: reset and first retires
    repeat (10) @(negedge clk);
    chk_st("reset", 0, 0, 0, 0, 0, 1);
    i_reset = 1'b1;
    drive(1, 32'h0);
    drive(1, 32'h4);
    drive(1, 32'h8);
    chk_st("t1_run", 3, 0, 0, 0, 3, 0);
    drive(0, 32'h0);
    chk_st("t1_halt", 3, 0, 1, 1, 4, 0);
    rd("t1_rd0", 4'd0, 32'h0, 32'd0);
    rd("t1_rd1", 4'd1, 32'h4, 32'd1);
    rd("t1_rd2", 4'd2, 32'h8, 32'd2);
    rd_req = 1'b0;
    chk_st("t1_frozen", 3, 0, 1, 1, 4, 0);

    // 2: wrap
    do_clear();
    for (int k = 0; k < 20; k++) drive(1, 32'(4 * k));
    drive(0, 32'h0);
    chk_st("t2_wrap", 16, 1, 1, 1, 21, 0);
    rd("t2_rd0", 4'd0, 32'h10, 32'd4);
    rd("t2_rd1", 4'd1, 32'h14, 32'd5);
    rd("t2_rd15", 4'd15, 32'h4C, 32'd19);
    rd_req = 1'b0;

    // 3: invalid, later retires ignored
    do_clear();
    for (int k = 0; k < 5; k++) drive(1, 32'(32'h200 + 4 * k));
    drive(0, 32'h0);
    chk_st("t3_halt", 5, 0, 1, 1, 6, 0);
    drive(1, 32'h300);
    drive(1, 32'h304);
    drive(1, 32'h308);
    chk_st("t3_ignored", 5, 0, 1, 1, 6, 0);
    rd("t3_rd4", 4'd4, 32'h210, 32'd4);
    rd_req = 1'b0;

    // 4: self-loop
    do_clear();
    for (int k = 0; k < 7; k++) drive(1, 32'h100);
    chk_st("t4_seven", 7, 0, 0, 0, 7, 0);
    drive(1, 32'h100);
    chk_st("t4_loop", 8, 0, 1, 2, 8, 0);
    drive(1, 32'h100);
    chk_st("t4_frozen", 8, 0, 1, 2, 8, 0);
    rd("t4_rd7", 4'd7, 32'h100, 32'd7);
    rd_req = 1'b0;
    do_clear();
    for (int k = 0; k < 7; k++) drive(1, 32'h100);
    drive(1, 32'h104);
    drive(1, 32'h100);
    chk_st("t4_noloop", 9, 0, 0, 0, 9, 0);
    drive(0, 32'h0);
    chk_st("t4_inv", 9, 0, 1, 1, 10, 0);

    // 5: timeout and priority
    do_clear();
    for (int k = 0; k < 49; k++) drive(1, 32'(4 * k));
    chk_st("t5_pre", 16, 1, 0, 0, 49, 0);
    drive(1, 32'(4 * 49));
    chk_st("t5_timeout", 16, 1, 1, 3, 50, 0);
    drive(1, 32'h999);
    chk_st("t5_frozen", 16, 1, 1, 3, 50, 0);
    rd("t5_rd15", 4'd15, 32'hC4, 32'd49);
    rd("t5_rd0", 4'd0, 32'h88, 32'd34);
    rd_req = 1'b0;
    do_clear();
    for (int k = 0; k < 49; k++) drive(1, 32'(4 * k));
    drive(0, 32'h0);
    chk_st("t5_prio", 16, 1, 1, 1, 50, 0);

    // 6: async reset mid-run, clear during halt
    do_clear();
    drive(1, 32'h500);
    drive(1, 32'h504);
    drive(1, 32'h508);
    chk_st("t6_run", 3, 0, 0, 0, 3, 0);
    #2;
    i_reset = 1'b0;
    chk_st("t6_async", 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    i_reset = 1'b1;
    drive(1, 32'h40);
    drive(0, 32'h0);
    chk_st("t6_halt", 1, 0, 1, 1, 2, 0);
    do_clear();
    chk_st("t6_clear", 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    check("queues_drained", 64'(st_q.size() + rd_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
